// File: rtl/num_display_seq.sv
// Sequencer between board switches/buttons and the 4-bit number display decoder:
// debounced digit capture into a small buffer, then timed playback with ready strobes.

module num_display_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;

  logic             level;
  logic [CNT_W-1:0] run;

  // run counts consecutive samples that disagree with the accepted level;
  // any agreeing sample restarts it, so short glitches never flip the level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      level <= 1'b0;
      run   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn == level) begin
        run <= '0;
      end else if (run == CNT_W'(DEBOUNCE_CYC - 1)) begin
        level <= btn;
        run   <= '0;
        press <= btn;
      end else begin
        run <= run + CNT_W'(1);
      end
    end
  end
endmodule

module num_display_seq #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int DWELL_CYC    = 8,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               sw,
  input  logic                     btn_enter,
  input  logic                     btn_play,
  output logic [3:0]               digit_out,
  output logic                     ready_out,
  output logic                     dec_reset,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DWELL_CYC);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, DONE} state_t;

  state_t          state;
  logic   [CW-1:0] index;
  logic   [CW-1:0] next_index;
  logic   [DW-1:0] dwell;
  logic   [3:0]    digits [DEPTH];
  logic            enter_p;
  logic            play_p;
  logic            accept_digit;

  num_display_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_enter (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_enter),
    .press (enter_p)
  );

  num_display_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_play (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_play),
    .press (play_p)
  );

  assign accept_digit = (state == IDLE) && enter_p && (sw <= 4'd9) && (count < CW'(DEPTH));
  assign next_index   = index + CW'(1);

  // Buffer holds data only; its contents are meaningless once count is cleared.
  always_ff @(posedge clk) begin
    if (reset && accept_digit) begin
      digits[count[AW-1:0]] <= sw;
    end
  end

  // Outputs are set on the edge entering a state, so LOAD's strobe and
  // DONE's decoder reset are visible during exactly those state cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      digit_out <= '0;
      ready_out <= 1'b0;
      dec_reset <= 1'b1;
      count     <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      index     <= '0;
      dwell     <= '0;
    end else begin
      ready_out <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          dec_reset <= 1'b0;
          if (enter_p) begin
            if (accept_digit) begin
              count <= count + CW'(1);
            end else begin
              err <= 1'b1;
            end
          end else if (play_p) begin
            if (count == '0) begin
              err <= 1'b1;
            end else begin
              state     <= LOAD;
              index     <= '0;
              digit_out <= digits[0];
              ready_out <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        LOAD: begin
          state <= HOLD;
          dwell <= '0;
        end
        HOLD: begin
          if (dwell == DW'(DWELL_CYC - 2)) begin
            index <= next_index;
            if (next_index < count) begin
              state     <= LOAD;
              digit_out <= digits[next_index[AW-1:0]];
              ready_out <= 1'b1;
            end else begin
              state     <= DONE;
              dec_reset <= 1'b1;
              digit_out <= '0;
            end
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          dec_reset <= 1'b0;
          count     <= '0;
          index     <= '0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_num_display_seq.sv
// Randomized bench for num_display_seq: a digit queue plus strobe-timing arithmetic
// predict every observable output cycle by cycle.

module tb_num_display_seq;
  localparam int DEB   = 4;
  localparam int DWELL = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sw = '0;
  logic       btn_enter = 1'b0;
  logic       btn_play = 1'b0;
  logic [3:0] digit_out;
  logic       ready_out;
  logic       dec_reset;
  logic [2:0] count;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;
  logic [3:0] model_q[$];

  num_display_seq #(.DEBOUNCE_CYC(DEB), .DWELL_CYC(DWELL), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .btn_enter (btn_enter),
    .btn_play  (btn_play),
    .digit_out (digit_out),
    .ready_out (ready_out),
    .dec_reset (dec_reset),
    .count     (count),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the edge on which the FSM acts on the press.
  task automatic press_enter(input logic [3:0] v);
    sw = v;
    btn_enter = 1'b1;
    repeat (DEB) tick();
    btn_enter = 1'b0;
    tick();
  endtask

  // Returns in the cycle where play_p is high (cycle N).
  task automatic press_play_start();
    btn_play = 1'b1;
    repeat (DEB) tick();
    btn_play = 1'b0;
  endtask

  task automatic rearm();
    repeat (DEB) tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (digit_out !== 4'd0) begin errors++; $display("FAIL reset_digit: got %0d expected 0", digit_out); end
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", ready_out); end
    checks++; if (dec_reset !== 1'b1) begin errors++; $display("FAIL reset_dec: got %0b expected 1", dec_reset); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
    reset = 1'b1;
    tick();
    checks++; if (dec_reset !== 1'b0) begin errors++; $display("FAIL reset_release_dec: got %0b expected 0", dec_reset); end
    model_q.delete();
  endtask

  task automatic test_enter_debounce();
    logic [3:0] v;
    v = 4'($urandom_range(0, 9));
    press_enter(v);
    model_q.push_back(v);
    checks++; if (int'(count) !== model_q.size()) begin errors++; $display("FAIL enter_count: got %0d expected %0d", count, model_q.size()); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL enter_err: got %0b expected 0", err); end
    rearm();
    checks++; if (int'(count) !== model_q.size()) begin errors++; $display("FAIL enter_single: got %0d expected %0d", count, model_q.size()); end
    // glitch one sample too short
    sw = 4'($urandom_range(0, 9));
    btn_enter = 1'b1;
    repeat (DEB - 1) tick();
    btn_enter = 1'b0;
    repeat (DEB + 2) tick();
    checks++; if (int'(count) !== model_q.size()) begin errors++; $display("FAIL glitch_count: got %0d expected %0d", count, model_q.size()); end
    // long hold still yields one press
    v = 4'($urandom_range(0, 9));
    sw = v;
    btn_enter = 1'b1;
    repeat (3 * DEB) tick();
    btn_enter = 1'b0;
    repeat (DEB + 2) tick();
    model_q.push_back(v);
    checks++; if (int'(count) !== model_q.size()) begin errors++; $display("FAIL long_hold_count: got %0d expected %0d", count, model_q.size()); end
  endtask

  task automatic test_errors();
    logic [3:0] v;
    v = 4'($urandom_range(10, 15));
    press_enter(v);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_digit_err: got %0b expected 1", err); end
    checks++; if (int'(count) !== model_q.size()) begin errors++; $display("FAIL bad_digit_count: got %0d expected %0d", count, model_q.size()); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %0b expected 0", err); end
    repeat (DEB - 1) tick();
    while (model_q.size() < DEPTH) begin
      v = 4'($urandom_range(0, 9));
      press_enter(v);
      model_q.push_back(v);
      checks++; if (int'(count) !== model_q.size()) begin errors++; $display("FAIL fill_count: got %0d expected %0d", count, model_q.size()); end
      rearm();
    end
    press_enter(4'($urandom_range(0, 9)));
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL full_err: got %0b expected 1", err); end
    checks++; if (int'(count) !== DEPTH) begin errors++; $display("FAIL full_count: got %0d expected %0d", count, DEPTH); end
    rearm();
    reset = 1'b0; tick(); reset = 1'b1; tick();
    model_q.delete();
    press_play_start();
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL empty_play_err: got %0b expected 1", err); end
    for (int i = 0; i < 2 * DWELL; i++) begin
      tick();
      checks++; if (busy !== 1'b0 || ready_out !== 1'b0) begin errors++; $display("FAIL empty_play_idle: got busy=%0b ready=%0b expected 0 0", busy, ready_out); end
    end
  endtask

  task automatic test_playback();
    logic [3:0] v;
    int n, rel, k;
    logic exp_ready, exp_busy, exp_dec;
    for (int round = 0; round < 4; round++) begin
      n = (round == 0) ? 3 : int'($urandom_range(1, DEPTH));
      while (model_q.size() < n) begin
        if (round == 0) v = (model_q.size() == 0) ? 4'd3 : (model_q.size() == 1) ? 4'd9 : 4'd0;
        else if ($urandom_range(0, 3) == 0) v = 4'($urandom_range(10, 15));
        else v = 4'($urandom_range(0, 9));
        press_enter(v);
        if (v <= 4'd9) model_q.push_back(v);
        checks++; if (err !== (v > 4'd9)) begin errors++; $display("FAIL load_err: got %0b expected %0b", err, v > 4'd9); end
        checks++; if (int'(count) !== model_q.size()) begin errors++; $display("FAIL load_count: got %0d expected %0d", count, model_q.size()); end
        rearm();
      end
      press_play_start();
      for (rel = 0; rel <= DWELL * n + 1; rel++) begin
        tick();
        k = rel / DWELL;
        exp_ready = (rel % DWELL == 0) && (k < n);
        exp_busy  = (rel <= DWELL * n);
        exp_dec   = (rel == DWELL * n);
        checks++; if (ready_out !== exp_ready) begin errors++; $display("FAIL play_ready rel=%0d: got %0b expected %0b", rel, ready_out, exp_ready); end
        checks++; if (busy !== exp_busy) begin errors++; $display("FAIL play_busy rel=%0d: got %0b expected %0b", rel, busy, exp_busy); end
        checks++; if (dec_reset !== exp_dec) begin errors++; $display("FAIL play_dec rel=%0d: got %0b expected %0b", rel, dec_reset, exp_dec); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL play_err rel=%0d: got %0b expected 0", rel, err); end
        if (k < n) begin
          checks++; if (digit_out !== model_q[k]) begin errors++; $display("FAIL play_digit rel=%0d: got %0d expected %0d", rel, digit_out, model_q[k]); end
        end
        if (exp_busy) begin
          checks++; if (int'(count) !== n) begin errors++; $display("FAIL play_count rel=%0d: got %0d expected %0d", rel, count, n); end
        end
      end
      model_q.delete();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL after_play_count: got %0d expected 0", count); end
      checks++; if (digit_out !== 4'd0) begin errors++; $display("FAIL after_play_digit: got %0d expected 0", digit_out); end
      rearm();
    end
  endtask

  task automatic test_same_cycle();
    logic [3:0] v;
    v = 4'($urandom_range(0, 9));
    press_enter(v);
    model_q.push_back(v);
    rearm();
    sw = 4'd5;
    btn_enter = 1'b1;
    btn_play = 1'b1;
    repeat (DEB) tick();
    btn_enter = 1'b0;
    btn_play = 1'b0;
    tick();
    model_q.push_back(4'd5);
    checks++; if (int'(count) !== model_q.size()) begin errors++; $display("FAIL same_cycle_count: got %0d expected %0d", count, model_q.size()); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL same_cycle_err: got %0b expected 0", err); end
    for (int i = 0; i < 2 * DWELL; i++) begin
      checks++; if (busy !== 1'b0 || ready_out !== 1'b0) begin errors++; $display("FAIL same_cycle_idle: got busy=%0b ready=%0b expected 0 0", busy, ready_out); end
      tick();
    end
  endtask

  task automatic test_press_during_hold();
    int n, rel, k;
    logic exp_ready;
    n = model_q.size();
    press_play_start();
    for (rel = 0; rel <= DWELL * n + 1; rel++) begin
      tick();
      if (rel == 2) begin sw = 4'($urandom_range(0, 9)); btn_enter = 1'b1; end
      if (rel == DEB + 4) btn_enter = 1'b0;
      k = rel / DWELL;
      exp_ready = (rel % DWELL == 0) && (k < n);
      checks++; if (ready_out !== exp_ready) begin errors++; $display("FAIL hold_press_ready rel=%0d: got %0b expected %0b", rel, ready_out, exp_ready); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL hold_press_err rel=%0d: got %0b expected 0", rel, err); end
      if (rel <= DWELL * n) begin
        checks++; if (int'(count) !== n) begin errors++; $display("FAIL hold_press_count rel=%0d: got %0d expected %0d", rel, count, n); end
      end
    end
    model_q.delete();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL hold_press_after: got %0d expected 0", count); end
    rearm();
  endtask

  task automatic test_reset_mid_hold();
    logic [3:0] v;
    while (model_q.size() < 3) begin
      v = 4'($urandom_range(0, 9));
      press_enter(v);
      model_q.push_back(v);
      rearm();
    end
    press_play_start();
    for (int rel = 0; rel <= DWELL + 3; rel++) begin
      tick();
      checks++; if (ready_out !== (rel % DWELL == 0)) begin errors++; $display("FAIL abort_pre_ready rel=%0d: got %0b expected %0b", rel, ready_out, rel % DWELL == 0); end
    end
    reset = 1'b0;
    repeat (2) tick();
    model_q.delete();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL abort_count: got %0d expected 0", count); end
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL abort_ready: got %0b expected 0", ready_out); end
    checks++; if (dec_reset !== 1'b1) begin errors++; $display("FAIL abort_dec: got %0b expected 1", dec_reset); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    reset = 1'b1;
    tick();
    checks++; if (dec_reset !== 1'b0) begin errors++; $display("FAIL abort_dec_release: got %0b expected 0", dec_reset); end
    for (int i = 0; i < 4 * DWELL; i++) begin
      tick();
      checks++; if (ready_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_resume: got ready=%0b busy=%0b expected 0 0", ready_out, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_enter_debounce();
    test_errors();
    test_playback();
    test_same_cycle();
    test_press_during_hold();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
